viterbi_ber_check: RTL and testbench

VITERBI_BER_CHECK -- requirements
Module: viterbi_ber_check

---
 rtl/viterbi_pkg.sv | 23 ++
 rtl/sat_counter.sv | 41 ++++
 rtl/viterbi_ber_check.sv | 189 ++++++++++++++++++
 tb/tb_viterbi_ber_check.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/viterbi_pkg.sv
// ============================================================================
// Module : viterbi_pkg
// Brief  : Shared FSM state type and default parameters for viterbi_ber_check.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package viterbi_pkg;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_LOCKED = 2'd1,
        ST_HOLD   = 2'd2
    } ber_state_t;

    localparam int c_def_max_lat  = 64;
    localparam int c_def_lock_run = 32;
    localparam int c_def_win      = 256;
    localparam int c_def_loss_thr = 16;

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// Module : sat_counter
// Brief  : Up-counter that sticks at all-ones; synchronous clear beats increment.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/viterbi_ber_check.sv
// ============================================================================
// Module : viterbi_ber_check
// Brief  : Finds the decoder latency against a reference stream, then tracks
//          bit/error statistics while locked. Burst tracking: VITERBI_BER_BURST_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module viterbi_ber_check
    import viterbi_pkg::*;
#(
    parameter int MAX_LAT  = c_def_max_lat,
    parameter int LOCK_RUN = c_def_lock_run,
    parameter int WIN      = c_def_win,
    parameter int LOSS_THR = c_def_loss_thr
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ref_valid_i,
    input  logic                       ref_bit_i,
    input  logic                       dec_valid_i,
    input  logic                       dec_bit_i,
    input  logic                       clear_i,
    output logic                       locked_o,
    output logic [$clog2(MAX_LAT)-1:0] latency_o,
    output logic [31:0]                bit_count_o,
    output logic [31:0]                err_count_o,
    output logic [15:0]                max_burst_o,
    output logic [1:0]                 state_o
);

    localparam int c_lat_w = $clog2(MAX_LAT);
    localparam int c_run_w = $clog2(LOCK_RUN + 1);
    localparam int c_win_w = $clog2(WIN + 1);

    ber_state_t           state_q, state_d;
    logic [MAX_LAT-1:0]   hist_q;
    logic [c_lat_w-1:0]   k_q, k_d;
    logic [c_lat_w-1:0]   lat_q, lat_d;
    logic [c_run_w-1:0]   run_q, run_d;
    logic [c_win_w-1:0]   win_cnt_q, win_cnt_d;
    logic [c_win_w-1:0]   win_err_q, win_err_d;
    logic                 w_match;
    logic                 w_bit_inc;
    logic                 w_err_inc;
    logic [c_win_w-1:0]   w_win_err_nxt;

    // Compare reads the history as it stood before any same-cycle shift.
    assign w_match       = (dec_bit_i == hist_q[k_q]);
    assign w_win_err_nxt = win_err_q + c_win_w'(!w_match);

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        lat_d     = lat_q;
        run_d     = run_q;
        win_cnt_d = win_cnt_q;
        win_err_d = win_err_q;
        w_bit_inc = 1'b0;
        w_err_inc = 1'b0;
        case (state_q)
            ST_LOCKED: begin
                if (dec_valid_i) begin
                    w_bit_inc = 1'b1;
                    w_err_inc = !w_match;
                    if (win_cnt_q == c_win_w'(WIN - 1)) begin
                        if (w_win_err_nxt > c_win_w'(LOSS_THR)) begin
                            state_d = ST_HOLD;
                        end
                        win_cnt_d = '0;
                        win_err_d = '0;
                    end else begin
                        win_cnt_d = win_cnt_q + c_win_w'(1);
                        win_err_d = w_win_err_nxt;
                    end
                end
            end
            ST_HOLD: begin
                state_d   = ST_SEARCH;
                k_d       = '0;
                run_d     = '0;
                win_cnt_d = '0;
                win_err_d = '0;
            end
            default: begin
                // Also recovers the unused encoding 3.
                state_d = ST_SEARCH;
                if (dec_valid_i) begin
                    if (w_match) begin
                        if (run_q == c_run_w'(LOCK_RUN - 1)) begin
                            state_d = ST_LOCKED;
                            lat_d   = k_q;
                            run_d   = '0;
                        end else begin
                            run_d = run_q + c_run_w'(1);
                        end
                    end else begin
                        run_d = '0;
                        k_d   = (k_q == c_lat_w'(MAX_LAT - 1)) ? '0 : k_q + c_lat_w'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_SEARCH;
            hist_q    <= '0;
            k_q       <= '0;
            lat_q     <= '0;
            run_q     <= '0;
            win_cnt_q <= '0;
            win_err_q <= '0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            lat_q     <= lat_d;
            run_q     <= run_d;
            win_cnt_q <= win_cnt_d;
            win_err_q <= win_err_d;
            if (ref_valid_i) begin
                hist_q <= {hist_q[MAX_LAT-2:0], ref_bit_i};
            end
        end
    end

    sat_counter #(.WIDTH(32)) u_bit_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (clear_i),
        .inc_i   (w_bit_inc),
        .count_o (bit_count_o)
    );

    sat_counter #(.WIDTH(32)) u_err_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (clear_i),
        .inc_i   (w_err_inc),
        .count_o (err_count_o)
    );

`ifdef VITERBI_BER_BURST_EN
    logic [15:0] burst_cur_q, burst_cur_d;
    logic [15:0] burst_max_q, burst_max_d;

    always_comb begin
        burst_cur_d = burst_cur_q;
        burst_max_d = burst_max_q;
        if (clear_i) begin
            burst_cur_d = '0;
            burst_max_d = '0;
        end else if (state_q != ST_LOCKED) begin
            burst_cur_d = '0;
        end else if (w_bit_inc) begin
            if (w_err_inc) begin
                burst_cur_d = (burst_cur_q == 16'hFFFF) ? burst_cur_q : burst_cur_q + 16'd1;
                if (burst_cur_d > burst_max_q) begin
                    burst_max_d = burst_cur_d;
                end
            end else begin
                burst_cur_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            burst_cur_q <= '0;
            burst_max_q <= '0;
        end else begin
            burst_cur_q <= burst_cur_d;
            burst_max_q <= burst_max_d;
        end
    end

    assign max_burst_o = burst_max_q;
`else
    assign max_burst_o = '0;
`endif

    assign locked_o  = (state_q == ST_LOCKED);
    assign latency_o = lat_q;
    assign state_o   = state_q;

endmodule

`default_nettype wire

// File: tb/tb_viterbi_ber_check.sv
// ============================================================================
// Module : tb_viterbi_ber_check
// Brief  : Scoreboard bench: stimulus queues expected outputs, a negedge
//          monitor pops and compares them. Honours VITERBI_BER_BURST_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_viterbi_ber_check;

`ifdef VITERBI_BER_BURST_EN
    localparam bit c_burst = 1'b1;
`else
    localparam bit c_burst = 1'b0;
`endif

    localparam bit [5:0] c_all = 6'h3F;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ref_valid_i = 1'b0;
    logic        ref_bit_i = 1'b0;
    logic        dec_valid_i = 1'b0;
    logic        dec_bit_i = 1'b0;
    logic        clear_i = 1'b0;
    logic        locked_o;
    logic [5:0]  latency_o;
    logic [31:0] bit_count_o;
    logic [31:0] err_count_o;
    logic [15:0] max_burst_o;
    logic [1:0]  state_o;

    viterbi_ber_check u_dut (
        .clk         (clk),
        .rst         (rst),
        .ref_valid_i (ref_valid_i),
        .ref_bit_i   (ref_bit_i),
        .dec_valid_i (dec_valid_i),
        .dec_bit_i   (dec_bit_i),
        .clear_i     (clear_i),
        .locked_o    (locked_o),
        .latency_o   (latency_o),
        .bit_count_o (bit_count_o),
        .err_count_o (err_count_o),
        .max_burst_o (max_burst_o),
        .state_o     (state_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        bit [5:0]    mask;   // locked, latency, bits, errs, burst, state
        logic        locked;
        logic [5:0]  lat;
        logic [31:0] bitc;
        logic [31:0] errc;
        logic [15:0] burst;
        logic [1:0]  st;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    function automatic logic [15:0] bexp(input int v);
        return c_burst ? 16'(v) : 16'd0;
    endfunction

    task automatic push(input string name, input bit [5:0] mask, input logic locked,
                        input logic [5:0] lat, input logic [31:0] bitc, input logic [31:0] errc,
                        input logic [15:0] burst, input logic [1:0] st);
        exp_t e;
        e.name = name; e.mask = mask; e.locked = locked; e.lat = lat;
        e.bitc = bitc; e.errc = errc; e.burst = burst; e.st = st;
        exp_q.push_back(e);
    endtask

    function automatic void cmp(input string name, input string fld,
                                input longint unsigned got, input longint unsigned req);
        vectors++;
        if (got != req) begin
            miscompares++;
            $display("FAIL %s.%s: got %0d, expected %0d", name, fld, got, req);
        end
    endfunction

    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            if (e.mask[0]) cmp(e.name, "locked",  locked_o,    e.locked);
            if (e.mask[1]) cmp(e.name, "latency", latency_o,   e.lat);
            if (e.mask[2]) cmp(e.name, "bits",    bit_count_o, e.bitc);
            if (e.mask[3]) cmp(e.name, "errs",    err_count_o, e.errc);
            if (e.mask[4]) cmp(e.name, "burst",   max_burst_o, e.burst);
            if (e.mask[5]) cmp(e.name, "state",   state_o,     e.st);
        end
    end

    // Reference stream: PRBS-7, decoder modelled as a pure D-beat delay.
    bit [6:0] lfsr = 7'h7F;
    bit       refbuf[128];
    int       n = 0;
    int       dly = 20;

    task automatic restart_stream(input int d);
        n   = 0;
        dly = d;
        for (int i = 0; i < 128; i++) refbuf[i] = 1'b0;
    endtask

    // Beat: ref bit in one cycle, delayed decoded bit in the next.
    task automatic beat(input bit flip, input bit clr);
        bit b;
        b = lfsr[6];
        lfsr = {lfsr[5:0], lfsr[6] ^ lfsr[5]};
        refbuf[n % 128] = b;
        ref_valid_i = 1'b1;
        ref_bit_i   = b;
        @(posedge clk); #1;
        ref_valid_i = 1'b0;
        dec_valid_i = 1'b1;
        dec_bit_i   = ((n >= dly) ? refbuf[(n - dly) % 128] : 1'b0) ^ flip;
        clear_i     = clr;
        @(posedge clk); #1;
        dec_valid_i = 1'b0;
        clear_i     = 1'b0;
        n++;
    endtask

    task automatic wait_lock(input int max_beats);
        for (int i = 0; i < max_beats; i++) begin
            if (locked_o) break;
            beat(1'b0, 1'b0);
        end
    endtask

    task automatic pulse_reset(input string name);
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        push(name, c_all, 1'b0, 6'd0, 32'd0, 32'd0, 16'd0, 2'd0);
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        push("reset", c_all, 1'b0, 6'd0, 32'd0, 32'd0, 16'd0, 2'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Error-free link, delay 20
        restart_stream(20);
        wait_lock(400);
        push("lock20", c_all, 1'b1, 6'd20, 32'd0, 32'd0, 16'd0, 2'd1);

        // Five-bit error burst while locked
        for (int i = 0; i < 25; i++) beat(i >= 10 && i < 15, 1'b0);
        push("burst5", c_all, 1'b1, 6'd20, 32'd25, 32'd5, bexp(5), 2'd1);

        // Clear coincident with a locked mismatch
        beat(1'b1, 1'b1);
        push("clear", c_all, 1'b1, 6'd20, 32'd0, 32'd0, 16'd0, 2'd1);

        // Window now holds 26 compares / 6 errors; 11 more errors -> 17 at compare 256
        for (int i = 0; i < 230; i++) begin
            beat(i < 11, 1'b0);
            if (i == 228) push("win255", 6'h21, 1'b1, 6'd0, 32'd0, 32'd0, 16'd0, 2'd1);
        end
        push("hold", c_all, 1'b0, 6'd20, 32'd230, 32'd11, bexp(11), 2'd2);
        @(posedge clk); #1;
        push("search", 6'h3D, 1'b0, 6'd0, 32'd230, 32'd11, bexp(11), 2'd0);

        // Relock from k=0; search compares leave the counters untouched
        wait_lock(400);
        push("relock", c_all, 1'b1, 6'd20, 32'd230, 32'd11, bexp(11), 2'd1);

        // Exactly LOSS_THR errors in a window keeps lock
        for (int i = 0; i < 256; i++) beat(i < 16, 1'b0);
        push("thr16", c_all, 1'b1, 6'd20, 32'd486, 32'd27, bexp(16), 2'd1);

        // Reset mid-lock, then relock at the same latency
        pulse_reset("rst_midlock");
        restart_stream(20);
        wait_lock(400);
        push("rst_relock", c_all, 1'b1, 6'd20, 32'd0, 32'd0, 16'd0, 2'd1);

        // Largest searchable latency
        pulse_reset("rst_d63");
        restart_stream(63);
        wait_lock(1500);
        push("lock63", c_all, 1'b1, 6'd63, 32'd0, 32'd0, 16'd0, 2'd1);

        // One beyond the search range never locks
        pulse_reset("rst_d64");
        restart_stream(64);
        for (int i = 1; i <= 10000; i++) begin
            beat(1'b0, 1'b0);
            if (i % 1000 == 0) push("nolock64", 6'h2D, 1'b0, 6'd0, 32'd0, 32'd0, 16'd0, 2'd0);
        end

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #(5_000_000);
        miscompares++;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
